// File: rtl/cyclic_codec_serial_pkg.sv
// Shared types and default Hamming(7,4) constants for the serial cyclic codec.
// Provides the FSM state enum and the encode/check mode encodings.
package cyclic_codec_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_CHK = 1'b1;

   localparam int unsigned DEF_N    = 7;
   localparam int unsigned DEF_K    = 4;
   localparam logic [3:0]  DEF_POLY = 4'b1011;

endpackage

// File: rtl/cyclic_lfsr_div.sv
// Bit-serial polynomial division register: one division step per enabled cycle.
// clr has priority over en and zeroes the remainder.
module cyclic_lfsr_div #(
   parameter int unsigned M    = 3,
   parameter logic [M:0]  POLY = 4'b1011
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [M-1:0] r
);

   logic [M-1:0] r_q;
   logic [M-1:0] r_d;
   logic         fb;

   always_comb begin
      r_d = r_q;
      fb  = r_q[M-1] ^ din;
      if (clr) begin
         r_d = '0;
      end else if (en) begin
         r_d[0] = fb;
         for (int j = 1; j < M; j++) begin
            r_d[j] = r_q[j-1] ^ (POLY[j] & fb);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   assign r = r_q;

endmodule

// File: rtl/cyclic_codec_serial.sv
// Bit-serial systematic cyclic block codec: encode a K-bit message into an
// N-bit codeword, or compute the syndrome of a received N-bit word.
module cyclic_codec_serial
   import cyclic_codec_serial_pkg::*;
#(
   parameter int unsigned  N    = DEF_N,
   parameter int unsigned  K    = DEF_K,
   parameter logic [N-K:0] POLY = DEF_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_code,
   output logic [N-K-1:0]   out_syn,
   output logic             out_err
);

   localparam int unsigned M     = N - K;
   localparam int unsigned CNT_W = $clog2(N);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     word_q, word_d;
   logic             mode_q, mode_d;
   logic [N-1:0]     code_q, code_d;
   logic [M-1:0]     syn_q, syn_d;
   logic             err_q, err_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic             lfsr_clr;
   logic             lfsr_en;
   logic             lfsr_din;
   logic [M-1:0]     r;
   logic [M-1:0]     r_fin;
   logic             fb_fin;

   cyclic_lfsr_div #(
      .M    (M),
      .POLY (POLY)
   ) u_div (
      .clk (clk),
      .rst (rst),
      .clr (lfsr_clr),
      .en  (lfsr_en),
      .din (lfsr_din),
      .r   (r)
   );

   // Next state, LFSR control and result loading; the final remainder is
   // formed here so the results load on the same edge as the last step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      mode_d   = mode_q;
      code_d   = code_q;
      syn_d    = syn_q;
      err_d    = err_q;
      lfsr_clr = 1'b0;
      lfsr_en  = 1'b0;
      lfsr_din = word_q[cnt_q];

      fb_fin   = r[M-1] ^ lfsr_din;
      r_fin    = '0;
      r_fin[0] = fb_fin;
      for (int j = 1; j < M; j++) begin
         r_fin[j] = r[j-1] ^ (POLY[j] & fb_fin);
      end

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               word_d   = in_data;
               mode_d   = in_mode;
               cnt_d    = '0;
               lfsr_clr = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            lfsr_en = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(K - 1)) begin
               state_d = DONE;
               code_d  = word_q;
               syn_d   = '0;
               for (int j = 0; j < M; j++) begin
                  if (mode_q == MODE_ENC) begin
                     code_d[K+j] = r_fin[M-1-j];
                  end else begin
                     syn_d[j] = word_q[K+j] ^ r_fin[M-1-j];
                  end
               end
               err_d = |syn_d;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         mode_q      <= MODE_ENC;
         code_q      <= '0;
         syn_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         mode_q      <= mode_d;
         code_q      <= code_d;
         syn_q       <= syn_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_code  = code_q;
   assign out_syn   = syn_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_cyclic_codec_serial.sv
// Scoreboard bench for the serial cyclic codec with default Hamming(7,4) parameters.
module tb_cyclic_codec_serial;

   localparam int K = 4;

   typedef struct packed {
      logic [6:0] code;
      logic [2:0] syn;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_mode;
   logic [6:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_code;
   logic [2:0] out_syn;
   logic       out_err;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   cyclic_codec_serial #(
      .N    (7),
      .K    (4),
      .POLY (4'b1011)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_syn   (out_syn),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Present a word and wait for acceptance; returns at the negedge after the accept edge.
   task automatic send_word(input logic mode, input logic [6:0] data, output int acc_cyc);
      int w;
      in_mode  = mode;
      in_data  = data;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL accept_wait: in_ready=%0b, required 1", in_ready);
      end
      @(negedge clk);
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks += 5;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b, required 0", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
      if (out_code !== 7'h00) begin n_fail++; $display("FAIL reset out_code: got %h, required 00", out_code); end
      if (out_syn !== 3'b000) begin n_fail++; $display("FAIL reset out_syn: got %b, required 000", out_syn); end
      if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset out_err: got %b, required 0", out_err); end
      rst = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset in_ready: got %b, required 1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset out_valid: got %b, required 0", out_valid); end
   endtask

   // Encode table; upper in_data bits are garbage in two entries and must be ignored.
   task automatic test_encode();
      logic [6:0] msg [4] = '{7'h01, 7'h0F, 7'h78, 7'h70};
      logic [6:0] cw  [4] = '{7'h51, 7'h7F, 7'h68, 7'h00};
      int acc, w;
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.code = cw[i]; e.syn = 3'b000; e.err = 1'b0;
         sb.push_back(e);
         send_word(1'b0, msg[i], acc);
         w = 0;
         while (!out_valid && w < 40) begin @(negedge clk); w++; end
         n_checks++;
         if (!out_valid || (cyc - acc) != K) begin
            n_fail++;
            $display("FAIL enc%0d latency: got %0d edges (valid=%b), required %0d", i, cyc - acc, out_valid, K);
         end
         if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 3;
            if (out_code !== e.code) begin n_fail++; $display("FAIL enc%0d out_code: got %h, required %h", i, out_code, e.code); end
            if (out_syn !== e.syn) begin n_fail++; $display("FAIL enc%0d out_syn: got %b, required %b", i, out_syn, e.syn); end
            if (out_err !== e.err) begin n_fail++; $display("FAIL enc%0d out_err: got %b, required %b", i, out_err, e.err); end
         end
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL enc%0d handshake out_valid: got %b, required 0", i, out_valid); end
      end
   endtask

   task automatic test_check();
      logic [6:0] rx  [4] = '{7'h51, 7'h41, 7'h50, 7'h7F};
      logic [2:0] syn [4] = '{3'b000, 3'b001, 3'b101, 3'b000};
      logic       err [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      int acc, w;
      exp_t e;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.code = rx[i]; e.syn = syn[i]; e.err = err[i];
         sb.push_back(e);
         send_word(1'b1, rx[i], acc);
         w = 0;
         while (!out_valid && w < 40) begin @(negedge clk); w++; end
         n_checks++;
         if (!out_valid || (cyc - acc) != K) begin
            n_fail++;
            $display("FAIL chk%0d latency: got %0d edges (valid=%b), required %0d", i, cyc - acc, out_valid, K);
         end
         if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 3;
            if (out_code !== e.code) begin n_fail++; $display("FAIL chk%0d out_code: got %h, required %h", i, out_code, e.code); end
            if (out_syn !== e.syn) begin n_fail++; $display("FAIL chk%0d out_syn: got %b, required %b", i, out_syn, e.syn); end
            if (out_err !== e.err) begin n_fail++; $display("FAIL chk%0d out_err: got %b, required %b", i, out_err, e.err); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int acc, w;
      exp_t e;
      out_ready = 1'b0;
      e.code = 7'h7F; e.syn = 3'b000; e.err = 1'b0;
      sb.push_back(e);
      send_word(1'b0, 7'h0F, acc);
      w = 0;
      while (!out_valid && w < 40) begin @(negedge clk); w++; end
      // Offer a competing word while the result is stalled.
      in_valid = 1'b1; in_mode = 1'b0; in_data = 7'h01;
      for (int i = 0; i < 10; i++) begin
         n_checks += 3;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d out_valid: got %b, required 1", i, out_valid); end
         if (out_code !== 7'h7F) begin n_fail++; $display("FAIL bp%0d out_code: got %h, required 7f", i, out_code); end
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d in_ready: got %b, required 0", i, in_ready); end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks += 3;
         if (out_code !== e.code) begin n_fail++; $display("FAIL bp out_code: got %h, required %h", out_code, e.code); end
         if (out_syn !== e.syn) begin n_fail++; $display("FAIL bp out_syn: got %b, required %b", out_syn, e.syn); end
         if (out_err !== e.err) begin n_fail++; $display("FAIL bp out_err: got %b, required %b", out_err, e.err); end
      end
      @(negedge clk);
      n_checks += 2;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release in_ready: got %b, required 1", in_ready); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_accept in_ready: got %b, required 1", in_ready); end
   endtask

   task automatic test_reset_midshift();
      int acc, w;
      exp_t e;
      out_ready = 1'b1;
      send_word(1'b0, 7'h0F, acc);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid out_valid: got %b, required 0", out_valid); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid in_ready: got %b, required 0", in_ready); end
      if (out_code !== 7'h00) begin n_fail++; $display("FAIL rst_mid out_code: got %h, required 00", out_code); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_quiet%0d out_valid: got %b, required 0", i, out_valid); end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle in_ready: got %b, required 1", in_ready); end
      e.code = 7'h51; e.syn = 3'b000; e.err = 1'b0;
      sb.push_back(e);
      send_word(1'b0, 7'h01, acc);
      w = 0;
      while (!out_valid && w < 40) begin @(negedge clk); w++; end
      n_checks++;
      if (!out_valid || (cyc - acc) != K) begin
         n_fail++;
         $display("FAIL rst_mid_enc latency: got %0d edges (valid=%b), required %0d", cyc - acc, out_valid, K);
      end
      if (out_valid && sb.size() > 0) begin
         e = sb.pop_front();
         n_checks += 3;
         if (out_code !== e.code) begin n_fail++; $display("FAIL rst_mid_enc out_code: got %h, required %h", out_code, e.code); end
         if (out_syn !== e.syn) begin n_fail++; $display("FAIL rst_mid_enc out_syn: got %b, required %b", out_syn, e.syn); end
         if (out_err !== e.err) begin n_fail++; $display("FAIL rst_mid_enc out_err: got %b, required %b", out_err, e.err); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [6:0] cw  [2] = '{7'h51, 7'h68};
      int         acc [2] = '{0, 0};
      int         nacc = 0;
      int         nres = 0;
      logic       pend = 1'b0;
      exp_t       e;
      out_ready = 1'b1;
      in_mode   = 1'b0;
      in_data   = 7'h01;
      in_valid  = 1'b1;
      for (int i = 0; i < 40 && nres < 2; i++) begin
         if (pend) begin
            pend = 1'b0;
            if (nacc == 1) in_data = 7'h08;
            else in_valid = 1'b0;
         end
         if (out_valid) begin
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_checks += 3;
               if (out_code !== e.code) begin n_fail++; $display("FAIL b2b%0d out_code: got %h, required %h", nres, out_code, e.code); end
               if (out_syn !== e.syn) begin n_fail++; $display("FAIL b2b%0d out_syn: got %b, required %b", nres, out_syn, e.syn); end
               if (out_err !== e.err) begin n_fail++; $display("FAIL b2b%0d out_err: got %b, required %b", nres, out_err, e.err); end
            end
            nres++;
         end
         if (in_valid && in_ready && nacc < 2) begin
            acc[nacc] = cyc;
            e.code = cw[nacc]; e.syn = 3'b000; e.err = 1'b0;
            sb.push_back(e);
            nacc++;
            pend = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks += 2;
      if (nres != 2) begin n_fail++; $display("FAIL b2b result_count: got %0d, required 2", nres); end
      if (nacc != 2 || (acc[1] - acc[0]) != K + 2) begin
         n_fail++;
         $display("FAIL b2b accept_spacing: got %0d cycles (%0d accepts), required %0d", acc[1] - acc[0], nacc, K + 2);
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_check();
      test_backpressure();
      test_reset_midshift();
      test_back_to_back();
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
